// File: rtl/ls_pkg.sv
// Shared load/store definitions: type codes, store flag position, queue entry layout.
package ls_pkg;

  typedef enum logic [2:0] {
    LS_LW = 3'b000,
    LS_LH = 3'b001,
    LS_LB = 3'b010,
    LS_SW = 3'b100,
    LS_SH = 3'b101,
    LS_SB = 3'b110
  } ls_type_e;

  localparam int LS_STORE_BIT = 2;
  localparam int LS_INS_W     = 32;

  typedef struct packed {
    ls_type_e             typ;
    logic [LS_INS_W-1:0]  ins;
  } ls_entry_t;

endpackage

// File: rtl/ls_queue_ctrl.sv
// Pointer/occupancy control for ls_queue: head/tail/count, wrap, pair-granular
// backpressure and flush.
module ls_queue_ctrl #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             ls_valid1_i,
  input  logic             ls_valid2_i,
  input  logic             deq_ready_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  output logic             deq_fire_o,
  output logic             we0_o,
  output logic             we1_o,
  output logic [PTR_W-1:0] wa0_o,
  output logic [PTR_W-1:0] wa1_o,
  output logic [PTR_W-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_n_enq, w_count_nxt;

  // Room for a full pair is required even for a single-slot enqueue.
  assign enq_ready_o = (r_count <= CNT_W'(DEPTH - 2));
  assign deq_valid_o = (r_count != '0);
  assign deq_fire_o  = deq_valid_o & deq_ready_i;

  assign we0_o  = enq_ready_o & ~flush_i & (ls_valid1_i | ls_valid2_i);
  assign we1_o  = enq_ready_o & ~flush_i & ls_valid1_i & ls_valid2_i;
  assign wa0_o  = r_tail;
  assign wa1_o  = r_tail + PTR_W'(1);
  assign head_o = r_head;

  assign w_n_enq     = CNT_W'(we0_o) + CNT_W'(we1_o);
  assign w_count_nxt = r_count + w_n_enq - CNT_W'(deq_fire_o);
  assign count_o     = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_n_enq);
      if (deq_fire_o) r_head <= r_head + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/ls_queue.sv
// In-order dual-enqueue / single-dequeue load/store queue.
// Optional dequeue statistics counters under `define LS_QUEUE_STATS_EN.
module ls_queue
  import ls_pkg::*;
#(
  parameter int INS_WIDTH = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       ls_valid1_i,
  input  logic                       ls_valid2_i,
  input  logic [2:0]                 ls_type1_i,
  input  logic [2:0]                 ls_type2_i,
  input  logic [INS_WIDTH-1:0]       ins1_i,
  input  logic [INS_WIDTH-1:0]       ins2_i,
  output logic                       enq_ready_o,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [2:0]                 deq_type_o,
  output logic [INS_WIDTH-1:0]       deq_ins_o,
  output logic                       deq_is_store_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
`ifdef LS_QUEUE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]       ld_cnt_o,
  output logic [CNT_WIDTH-1:0]       st_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || CNT_WIDTH < 1) begin : g_bad_param
    $error("ls_queue: DEPTH must be a power of two >= 4, CNT_WIDTH >= 1");
  end

  logic             w_we0, w_we1, w_deq_fire;
  logic [PTR_W-1:0] w_wa0, w_wa1, w_head;

  ls_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .ls_valid1_i (ls_valid1_i),
    .ls_valid2_i (ls_valid2_i),
    .deq_ready_i (deq_ready_i),
    .enq_ready_o (enq_ready_o),
    .deq_valid_o (deq_valid_o),
    .deq_fire_o  (w_deq_fire),
    .we0_o       (w_we0),
    .we1_o       (w_we1),
    .wa0_o       (w_wa0),
    .wa1_o       (w_wa1),
    .head_o      (w_head),
    .count_o     (count_o)
  );

  // Storage is not reset; head fields are meaningless while deq_valid_o is low.
  logic [2:0]           r_typ_mem [DEPTH];
  logic [INS_WIDTH-1:0] r_ins_mem [DEPTH];

  // A lone slot-2 instruction still lands at the tail.
  always_ff @(posedge clk_i) begin
    if (w_we0) begin
      r_typ_mem[w_wa0] <= ls_valid1_i ? ls_type1_i : ls_type2_i;
      r_ins_mem[w_wa0] <= ls_valid1_i ? ins1_i     : ins2_i;
    end
    if (w_we1) begin
      r_typ_mem[w_wa1] <= ls_type2_i;
      r_ins_mem[w_wa1] <= ins2_i;
    end
  end

  assign deq_type_o     = r_typ_mem[w_head];
  assign deq_ins_o      = r_ins_mem[w_head];
  assign deq_is_store_o = deq_type_o[LS_STORE_BIT];
  assign empty_o        = (count_o == '0);
  assign full_o         = (count_o == ($clog2(DEPTH)+1)'(DEPTH));

`ifdef LS_QUEUE_STATS_EN
  logic [CNT_WIDTH-1:0] r_ld_cnt, r_st_cnt;

  // Flush does not clear the statistics; a handshake in the flush cycle counts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ld_cnt <= '0;
      r_st_cnt <= '0;
    end else if (w_deq_fire) begin
      if (deq_is_store_o) begin
        if (r_st_cnt != '1) r_st_cnt <= r_st_cnt + CNT_WIDTH'(1);
      end else begin
        if (r_ld_cnt != '1) r_ld_cnt <= r_ld_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign ld_cnt_o = r_ld_cnt;
  assign st_cnt_o = r_st_cnt;
`else
  logic w_deq_fire_unused;
  assign w_deq_fire_unused = w_deq_fire;
`endif

endmodule

// File: tb/tb_ls_queue.sv
// Scoreboard bench for ls_queue: stimulus pushes expected entries, a negedge
// monitor pops and compares on every dequeue handshake.
module tb_ls_queue;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1, flush_i = 1'b0;
  logic           ls_valid1_i = 1'b0, ls_valid2_i = 1'b0;
  logic [2:0]     ls_type1_i = '0, ls_type2_i = '0;
  logic [W-1:0]   ins1_i = '0, ins2_i = '0;
  logic           deq_ready_i = 1'b0;
  logic           enq_ready_o, deq_valid_o, deq_is_store_o, empty_o, full_o;
  logic [2:0]     deq_type_o;
  logic [W-1:0]   deq_ins_o;
  logic [3:0]     count_o;
`ifdef LS_QUEUE_STATS_EN
  logic [CW-1:0]  ld_cnt_o, st_cnt_o;
`endif

  always #5 clk = ~clk;

  ls_queue #(.INS_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .ls_valid1_i(ls_valid1_i), .ls_valid2_i(ls_valid2_i),
    .ls_type1_i(ls_type1_i), .ls_type2_i(ls_type2_i),
    .ins1_i(ins1_i), .ins2_i(ins2_i),
    .enq_ready_o(enq_ready_o), .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_type_o(deq_type_o), .deq_ins_o(deq_ins_o), .deq_is_store_o(deq_is_store_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
`ifdef LS_QUEUE_STATS_EN
    , .ld_cnt_o(ld_cnt_o), .st_cnt_o(st_cnt_o)
`endif
  );

  typedef struct {
    logic [2:0]   t;
    logic [W-1:0] i;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every dequeue handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_i && deq_valid_o && deq_ready_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_deq: got type %0h ins %0h with empty scoreboard", deq_type_o, deq_ins_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("deq_type", 64'(deq_type_o), 64'(mon_e.t));
        chk("deq_ins", 64'(deq_ins_o), 64'(mon_e.i));
        chk("deq_is_store", 64'(deq_is_store_o), 64'(mon_e.t[2]));
      end
    end
  end

  // One cycle of stimulus, presented just after the clock edge.
  task automatic drive(input bit v1, input logic [2:0] t1, input logic [W-1:0] i1,
                       input bit v2, input logic [2:0] t2, input logic [W-1:0] i2,
                       input bit dr, input bit fl);
    exp_t e;
    @(posedge clk); #1;
    if (flush_i) exp_q.delete();
    ls_valid1_i = v1; ls_type1_i = t1; ins1_i = i1;
    ls_valid2_i = v2; ls_type2_i = t2; ins2_i = i2;
    deq_ready_i = dr; flush_i = fl;
    if (enq_ready_o && !fl) begin
      if (v1) begin e.t = t1; e.i = i1; exp_q.push_back(e); end
      if (v2) begin e.t = t2; e.i = i2; exp_q.push_back(e); end
    end
  endtask

  task automatic idle(input bit dr);
    drive(1'b0, 3'b000, '0, 1'b0, 3'b000, '0, dr, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1; flush_i = 1'b0; deq_ready_i = 1'b0;
    ls_valid1_i = 1'b0; ls_valid2_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    chk("rst_deq_valid", 64'(deq_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
  endtask

  initial begin
    logic [2:0] t;

    // Reset and idle
    do_reset();

    // Dual enqueue LW/SB, consumer always ready
    drive(1'b1, 3'b000, 32'hA000_0001, 1'b1, 3'b110, 32'hB000_0002, 1'b1, 1'b0);
    @(negedge clk);
    chk("dual_no_bypass", 64'(deq_valid_o), 64'd0);
    idle(1'b1);
    @(negedge clk);
    chk("dual_count", 64'(count_o), 64'd2);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("dual_drained", 64'(exp_q.size()), 64'd0);

    // Fill to DEPTH with four dual enqueues
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'b000, 32'h1000_0000 + 32'(2*k), 1'b1, 3'b100, 32'h1000_0001 + 32'(2*k), 1'b0, 1'b0);
      @(negedge clk);
      chk("fill_count", 64'(count_o), 64'(2*k));
      chk("fill_enq_ready", 64'(enq_ready_o), 64'd1);
    end
    drive(1'b1, 3'b001, 32'hDEAD_0001, 1'b1, 3'b101, 32'hDEAD_0002, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 64'(count_o), 64'd8);
    chk("full_enq_ready", 64'(enq_ready_o), 64'd0);
    chk("full_flag", 64'(full_o), 64'd1);
    idle(1'b0);
    @(negedge clk);
    chk("full_ignored", 64'(count_o), 64'd8);
    // Full with simultaneous dequeue: head leaves, enqueue refused
    drive(1'b1, 3'b010, 32'hDEAD_0003, 1'b1, 3'b110, 32'hDEAD_0004, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 32'hDEAD_0005, 1'b0, 3'b000, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cnt7_count", 64'(count_o), 64'd7);
    chk("cnt7_enq_ready", 64'(enq_ready_o), 64'd0);
    chk("cnt7_full", 64'(full_o), 64'd0);
    idle(1'b0);
    @(negedge clk);
    chk("cnt7_single_ignored", 64'(count_o), 64'd7);
    for (int k = 0; k < 8; k++) idle(1'b1);
    @(negedge clk);
    chk("fill_empty", 64'(empty_o), 64'd1);
    chk("fill_drained", 64'(exp_q.size()), 64'd0);

    // Wrap: steady single enqueue + dequeue at count 3
    drive(1'b1, 3'b000, 32'h2000_00F0, 1'b1, 3'b001, 32'h2000_00F1, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'h2000_00F2, 1'b0, 3'b000, '0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      t = k[2:0];
      drive(1'b1, t, 32'h2000_0000 + 32'(k), 1'b0, 3'b000, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk("wrap_count", 64'(count_o), 64'd3);
    end
    for (int k = 0; k < 4; k++) idle(1'b1);
    @(negedge clk);
    chk("wrap_empty", 64'(count_o), 64'd0);
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);

    // Flush at count 5 with simultaneous dual enqueue
    drive(1'b1, 3'b000, 32'h3000_0000, 1'b1, 3'b100, 32'h3000_0001, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'h3000_0002, 1'b1, 3'b101, 32'h3000_0003, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'h3000_0004, 1'b0, 3'b000, '0, 1'b0, 1'b0);
    drive(1'b1, 3'b110, 32'h3000_0005, 1'b1, 3'b110, 32'h3000_0006, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_cycle_count", 64'(count_o), 64'd5);
    idle(1'b1);
    @(negedge clk);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_deq_valid", 64'(deq_valid_o), 64'd0);
    chk("flush_empty", 64'(empty_o), 64'd1);
    idle(1'b1);
    drive(1'b0, 3'b000, '0, 1'b1, 3'b101, 32'h3000_00AA, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("post_flush_drained", 64'(exp_q.size()), 64'd0);

    // Reset with entries in flight
    drive(1'b1, 3'b000, 32'h4000_0000, 1'b1, 3'b100, 32'h4000_0001, 1'b0, 1'b0);
    idle(1'b0);
    do_reset();

`ifdef LS_QUEUE_STATS_EN
    drive(1'b1, 3'b000, 32'h5000_0000, 1'b1, 3'b100, 32'h5000_0001, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'h5000_0002, 1'b1, 3'b101, 32'h5000_0003, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'h5000_0004, 1'b0, 3'b000, '0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) idle(1'b1);
    drive(1'b0, 3'b000, '0, 1'b0, 3'b000, '0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("stats_ld", 64'(ld_cnt_o), 64'd3);
    chk("stats_st", 64'(st_cnt_o), 64'd2);
    do_reset();
    chk("stats_ld_rst", 64'(ld_cnt_o), 64'd0);
    chk("stats_st_rst", 64'(st_cnt_o), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
